// File: rtl/mandel_pkg.sv
// Shared types and helpers for the fixed-point Mandelbrot engine.
// Q3.(WIDTH-3) format: escape threshold and saturation live here.
package mandel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int frac_of(input int w);
        return w - 3;
    endfunction

    function automatic int esc_of(input int w);
        return 4 << frac_of(w);
    endfunction

    localparam int ESC_THRESH = esc_of(12);

    function automatic logic signed [31:0] sat(
        input logic signed [31:0] v,
        input int                 w
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/mandel_step.sv
// One z <- z^2 + c step: next z, |z|^2 and the escape flag.
// Purely combinational; the FSM in mandel_iter_core registers it.
module mandel_step
    import mandel_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic signed [WIDTH-1:0] z_re,
    input  logic signed [WIDTH-1:0] z_im,
    input  logic signed [WIDTH-1:0] c_re,
    input  logic signed [WIDTH-1:0] c_im,
    output logic signed [WIDTH-1:0] z_re_nxt,
    output logic signed [WIDTH-1:0] z_im_nxt,
    output logic [WIDTH+2:0]        mag,
    output logic                    escape
);

    localparam int FRAC = frac_of(WIDTH);
    localparam int SW   = WIDTH + 3;
    localparam logic [SW-1:0] ESC = SW'(esc_of(WIDTH));

    logic signed [2*WIDTH-1:0] p_rr;
    logic signed [2*WIDTH-1:0] p_ii;
    logic signed [2*WIDTH-1:0] p_ri;
    logic signed [SW-1:0]      sq_re;
    logic signed [SW-1:0]      sq_im;
    logic signed [SW-1:0]      xy;
    logic signed [SW-1:0]      two_xy;
    logic signed [SW-1:0]      c_re_x;
    logic signed [SW-1:0]      c_im_x;
    logic signed [SW-1:0]      sum_re;
    logic signed [SW-1:0]      sum_im;
    logic signed [31:0]        sat_re;
    logic signed [31:0]        sat_im;
    logic                      unused_bits;

    // Full-width products; dropping the low FRAC bits is an
    // arithmetic shift that truncates toward -inf.
    assign p_rr  = z_re * z_re;
    assign p_ii  = z_im * z_im;
    assign p_ri  = z_re * z_im;
    assign sq_re = p_rr[2*WIDTH-1:FRAC];
    assign sq_im = p_ii[2*WIDTH-1:FRAC];
    assign xy    = p_ri[2*WIDTH-1:FRAC];

    // Squares are non-negative, so the magnitude is unsigned
    // and cannot overflow SW bits.
    assign mag    = $unsigned(sq_re) + $unsigned(sq_im);
    assign escape = (mag >= ESC);

    assign c_re_x = {{3{c_re[WIDTH-1]}}, c_re};
    assign c_im_x = {{3{c_im[WIDTH-1]}}, c_im};
    assign two_xy = xy <<< 1;
    assign sum_re = sq_re - sq_im + c_re_x;
    assign sum_im = two_xy + c_im_x;

    assign sat_re   = sat(32'(sum_re), WIDTH);
    assign sat_im   = sat(32'(sum_im), WIDTH);
    assign z_re_nxt = sat_re[WIDTH-1:0];
    assign z_im_nxt = sat_im[WIDTH-1:0];

    assign unused_bits = ^{p_rr[FRAC-1:0], p_ii[FRAC-1:0],
                           p_ri[FRAC-1:0], sat_re[31:WIDTH],
                           sat_im[31:WIDTH]};

endmodule

// File: rtl/mandel_iter_core.sv
// Mandelbrot escape-count engine: one point in, one count out,
// one iteration per clock between two valid/ready handshakes.
module mandel_iter_core
    import mandel_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int ITER_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] c_re,
    input  logic signed [WIDTH-1:0] c_im,
    input  logic [ITER_W-1:0]       max_iter,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ITER_W-1:0]       out_iter,
    output logic                    out_escaped
);

    state_t state;
    state_t state_nxt;

    logic signed [WIDTH-1:0] c_re_q;
    logic signed [WIDTH-1:0] c_im_q;
    logic [ITER_W-1:0]       max_q;
    logic signed [WIDTH-1:0] z_re;
    logic signed [WIDTH-1:0] z_im;
    logic [ITER_W-1:0]       cnt;
    logic signed [WIDTH-1:0] z_re_nxt;
    logic signed [WIDTH-1:0] z_im_nxt;
    logic [WIDTH+2:0]        mag;
    logic                    esc;
    logic                    lim;
    logic                    accept;

    mandel_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .z_re    (z_re),
        .z_im    (z_im),
        .c_re    (c_re_q),
        .c_im    (c_im_q),
        .z_re_nxt(z_re_nxt),
        .z_im_nxt(z_im_nxt),
        .mag     (mag),
        .escape  (esc)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_ready && in_valid;
    assign lim       = (cnt == max_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: escape or limit ends ITER; handshake ends DONE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = ITER;
            ITER:    if (esc || lim) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch the point, iterate z, capture the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_re_q      <= '0;
            c_im_q      <= '0;
            max_q       <= '0;
            z_re        <= '0;
            z_im        <= '0;
            cnt         <= '0;
            out_iter    <= '0;
            out_escaped <= 1'b0;
        end else if (accept) begin
            c_re_q <= c_re;
            c_im_q <= c_im;
            max_q  <= max_iter;
            z_re   <= '0;
            z_im   <= '0;
            cnt    <= '0;
        end else if (state == ITER) begin
            if (esc) begin
                out_iter    <= cnt;
                out_escaped <= 1'b1;
            end else if (lim) begin
                out_iter    <= max_q;
                out_escaped <= 1'b0;
            end else begin
                z_re <= z_re_nxt;
                z_im <= z_im_nxt;
                cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mandel_iter_core.sv
// Directed bench for mandel_iter_core with hand-computed results.
// Q3.9: 1.0 = 512.
module tb_mandel_iter_core;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [11:0] c_re = '0;
    logic signed [11:0] c_im = '0;
    logic [3:0]         max_iter = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [3:0]         out_iter;
    logic               out_escaped;

    int n_cmp = 0;
    int n_bad = 0;

    mandel_iter_core #(
        .WIDTH (12),
        .ITER_W(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .c_re       (c_re),
        .c_im       (c_im),
        .max_iter   (max_iter),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_iter   (out_iter),
        .out_escaped(out_escaped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after one.
    task automatic run_point(input string tag,
                             input logic signed [11:0] cr,
                             input logic signed [11:0] ci,
                             input logic [3:0] mi,
                             input logic [3:0] e_iter,
                             input logic e_esc,
                             input int e_lat);
        int lat;
        in_valid = 1'b1;
        c_re     = cr;
        c_im     = ci;
        max_iter = mi;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        c_re     = 12'sd77;
        c_im     = -12'sd99;
        max_iter = 4'd3;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(e_lat));
        chk({tag, ".iter"}, 32'(out_iter), 32'(e_iter));
        chk({tag, ".esc"}, 32'(out_escaped), 32'(e_esc));
        chk({tag, ".busy"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".drained"}, 32'(out_valid), 32'd0);
        chk({tag, ".idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_iter", 32'(out_iter), 32'd0);
        chk("rst.out_esc", 32'(out_escaped), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_point("origin", 12'sd0, 12'sd0, 4'd15, 4'd15, 1'b0, 16);
        run_point("two", 12'sd1024, 12'sd0, 4'd15, 4'd1, 1'b1, 2);
        run_point("one", 12'sd512, 12'sd0, 4'd15, 4'd2, 1'b1, 3);
        run_point("neg1", -12'sd512, 12'sd0, 4'd7, 4'd7, 1'b0, 8);
        run_point("max0", 12'sd1024, 12'sd0, 4'd0, 4'd0, 1'b0, 1);
        run_point("satur", 12'sd2047, 12'sd2047, 4'd15, 4'd1, 1'b1, 2);
        run_point("img", 12'sd0, 12'sd1024, 4'd15, 4'd1, 1'b1, 2);

        // Backpressure: result must freeze; new input ignored.
        begin
            int lat;
            in_valid = 1'b1;
            c_re     = 12'sd512;
            c_im     = 12'sd0;
            max_iter = 4'd15;
            @(posedge clk);
            #1;
            c_re     = 12'sd0;
            max_iter = 4'd9;
            lat = 0;
            while (!out_valid && lat < 40) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk("bp.latency", 32'(lat), 32'd3);
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                chk("bp.valid", 32'(out_valid), 32'd1);
                chk("bp.iter", 32'(out_iter), 32'd2);
                chk("bp.esc", 32'(out_escaped), 32'd1);
                chk("bp.in_ready", 32'(in_ready), 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                #1;
                chk("bp.no_accept", 32'(in_ready), 32'd1);
            end
        end

        // Reset mid-ITER: previous result (2/1) must clear at once.
        in_valid = 1'b1;
        c_re     = 12'sd0;
        c_im     = 12'sd0;
        max_iter = 4'd15;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        chk("mid.busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid.in_ready", 32'(in_ready), 32'd1);
        chk("mid.out_valid", 32'(out_valid), 32'd0);
        chk("mid.out_iter", 32'(out_iter), 32'd0);
        chk("mid.out_esc", 32'(out_escaped), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_point("post", 12'sd512, 12'sd0, 4'd15, 4'd2, 1'b1, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
